// File: rtl/auth_request_scheduler.sv
// Authentication request scheduler: two request FIFOs (PD, DEBUG) sharing one
// authentication driver through a round-robin grant with a completion timeout.
module auth_request_scheduler #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pd_req_valid,
   input  logic [7:0]       pd_req_byte,
   output logic             pd_req_ready,
   input  logic             dbg_req_valid,
   input  logic [7:0]       dbg_req_byte,
   output logic             dbg_req_ready,
   output logic             drv_req_valid,
   output logic [7:0]       drv_req_byte,
   output logic             drv_req_src,
   input  logic             drv_req_accept,
   input  logic             drv_done,
   input  logic             drv_error,
   output logic             drv_abort,
   output logic             err_timeout,
   output logic             err_bad_req,
   output logic [CNT_W-1:0] pd_count,
   output logic [CNT_W-1:0] dbg_count,
   output logic             busy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_OFFER = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [1:0]       state, state_nxt;
   logic [7:0]       pd_mem  [DEPTH];
   logic [7:0]       dbg_mem [DEPTH];
   logic [PTR_W-1:0] pd_wr_ptr, pd_rd_ptr, dbg_wr_ptr, dbg_rd_ptr;
   logic [TMR_W-1:0] timer;
   logic             rr_dbg;

   logic             pd_push, pd_role_ok, pd_wr_en, pd_bad, pd_pop;
   logic             dbg_push, dbg_role_ok, dbg_wr_en, dbg_bad, dbg_pop;
   logic             pd_pending, dbg_pending, any_pending, sel_dbg;
   logic [CNT_W-1:0] pd_count_nxt, dbg_count_nxt;
   logic             expired, release_grant, abort_grant;

   // Push qualification: only initiator/responder roles are queued
   assign pd_push     = pd_req_valid & pd_req_ready;
   assign pd_role_ok  = (pd_req_byte[5:4] == 2'b01) | (pd_req_byte[5:4] == 2'b10);
   assign pd_wr_en    = pd_push & pd_role_ok;
   assign pd_bad      = pd_push & ~pd_role_ok;
   assign dbg_push    = dbg_req_valid & dbg_req_ready;
   assign dbg_role_ok = (dbg_req_byte[5:4] == 2'b01) | (dbg_req_byte[5:4] == 2'b10);
   assign dbg_wr_en   = dbg_push & dbg_role_ok;
   assign dbg_bad     = dbg_push & ~dbg_role_ok;

   // Arbitration: pointer breaks ties, a lone non-empty FIFO always wins
   assign pd_pending  = (pd_count != '0);
   assign dbg_pending = (dbg_count != '0);
   assign any_pending = pd_pending | dbg_pending;
   assign sel_dbg     = dbg_pending & (rr_dbg | ~pd_pending);
   assign pd_pop      = (state == ST_IDLE) & pd_pending & ~sel_dbg;
   assign dbg_pop     = (state == ST_IDLE) & sel_dbg;

   assign pd_count_nxt  = pd_count + CNT_W'(pd_wr_en) - CNT_W'(pd_pop);
   assign dbg_count_nxt = dbg_count + CNT_W'(dbg_wr_en) - CNT_W'(dbg_pop);
   assign expired       = (timer == TMR_LAST);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: handshakes take precedence over timer expiry
   always_comb begin
      state_nxt     = state;
      release_grant = 1'b0;
      abort_grant   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_pending) state_nxt = ST_OFFER;
         end
         ST_OFFER: begin
            if (drv_req_accept) begin
               state_nxt = ST_WAIT;
            end else if (expired) begin
               state_nxt   = ST_IDLE;
               abort_grant = 1'b1;
            end
         end
         ST_WAIT: begin
            if (drv_done | drv_error) begin
               state_nxt     = ST_IDLE;
               release_grant = 1'b1;
            end else if (expired) begin
               state_nxt   = ST_IDLE;
               abort_grant = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Grant timer: zero while idle, saturates so a late accept still times out
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 timer <= '0;
      else if (state == ST_IDLE) timer <= '0;
      else if (!expired)         timer <= timer + TMR_W'(1);
   end

   // FIFO storage (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (pd_wr_en)  pd_mem[pd_wr_ptr]   <= pd_req_byte;
      if (dbg_wr_en) dbg_mem[dbg_wr_ptr] <= dbg_req_byte;
   end

   // FIFO pointers, occupancy and ready flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pd_wr_ptr     <= '0;
         pd_rd_ptr     <= '0;
         dbg_wr_ptr    <= '0;
         dbg_rd_ptr    <= '0;
         pd_count      <= '0;
         dbg_count     <= '0;
         pd_req_ready  <= 1'b1;
         dbg_req_ready <= 1'b1;
      end else begin
         if (pd_wr_en)  pd_wr_ptr  <= pd_wr_ptr + PTR_W'(1);
         if (pd_pop)    pd_rd_ptr  <= pd_rd_ptr + PTR_W'(1);
         if (dbg_wr_en) dbg_wr_ptr <= dbg_wr_ptr + PTR_W'(1);
         if (dbg_pop)   dbg_rd_ptr <= dbg_rd_ptr + PTR_W'(1);
         pd_count      <= pd_count_nxt;
         dbg_count     <= dbg_count_nxt;
         pd_req_ready  <= (pd_count_nxt != CNT_FULL);
         dbg_req_ready <= (dbg_count_nxt != CNT_FULL);
      end
   end

   // Driver-facing outputs, status pulses and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drv_req_valid <= 1'b0;
         drv_req_byte  <= 8'h00;
         drv_req_src   <= 1'b0;
         drv_abort     <= 1'b0;
         err_timeout   <= 1'b0;
         err_bad_req   <= 1'b0;
         busy          <= 1'b0;
         rr_dbg        <= 1'b1;
      end else begin
         drv_req_valid <= (state_nxt == ST_OFFER);
         busy          <= (state_nxt != ST_IDLE);
         drv_abort     <= abort_grant;
         err_timeout   <= abort_grant;
         err_bad_req   <= pd_bad | dbg_bad;
         if (release_grant | abort_grant) rr_dbg <= ~rr_dbg;
         if (pd_pop) begin
            drv_req_byte <= pd_mem[pd_rd_ptr];
            drv_req_src  <= 1'b0;
         end else if (dbg_pop) begin
            drv_req_byte <= dbg_mem[dbg_rd_ptr];
            drv_req_src  <= 1'b1;
         end
      end
   end

endmodule
